rv32_hart_pc_seq: RTL

Per-hart program-counter sequencer for the multi-hart (barrel) RV32 pipeline, parametrised in hart count and PC width. Each hart owns a PC register and a small issue state machine, and a round-robin scheduler offers one ready hart's PC to fetch per cycle. Resolved control flow returns from execute and updates that hart's PC: branches, JAL, JALR, MRET and AUIPC link values, plus asynchronous interrupt redirects that are queued per hart.

---
 rtl/rv32_hart_pc_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rv32_hart_pc_seq.sv
// rtl/rv32_hart_pc_seq.sv - per-hart PC registers, issue FSMs and round-robin fetch scheduler
package rv32_hart_pc_seq_pkg;
  typedef enum logic [3:0] {
    OP_OTHER, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_JAL, OP_JALR, OP_MRET, OP_AUIPC
  } rv32_opcode_enum_t;
  typedef logic [31:0] rv32_imm_t;
endpackage

module rv32_hart_pc_seq
  import rv32_hart_pc_seq_pkg::*;
#(
  parameter int NUM_HARTS = 8,
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] RESET_STRIDE = '0,
  localparam int HID_W = $clog2(NUM_HARTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_HARTS-1:0] hart_en,
  output logic                 fetch_valid,
  input  logic                 fetch_ready,
  output logic [HID_W-1:0]     fetch_hart,
  output logic [PC_W-1:0]      fetch_pc,
  input  logic                 wb_valid,
  input  logic [HID_W-1:0]     wb_hart,
  input  rv32_opcode_enum_t    wb_opcode,
  input  logic [PC_W-1:0]      wb_pc,
  input  rv32_imm_t            wb_imm,
  input  logic [31:0]          wb_rs1,
  input  logic [31:0]          wb_alu_res,
  input  logic [PC_W-1:0]      mret_target,
  input  logic                 irq_valid,
  input  logic [HID_W-1:0]     irq_hart,
  input  logic [PC_W-1:0]      irq_data,
  output logic                 wb_save_pc,
  output logic [31:0]          wb_link_val,
  output logic [NUM_HARTS-1:0] hart_busy
);

  typedef enum logic [1:0] {ST_DIS, ST_RDY, ST_WAIT} hart_state_t;

  hart_state_t       state_q [NUM_HARTS];
  hart_state_t       state_d [NUM_HARTS];
  logic [PC_W-1:0]   pc_q    [NUM_HARTS];
  logic [PC_W-1:0]   pc_d    [NUM_HARTS];
  logic [PC_W-1:0]   pend_q  [NUM_HARTS];
  logic [PC_W-1:0]   pend_d  [NUM_HARTS];
  logic [NUM_HARTS-1:0] pend_v_q, pend_v_d;
  logic [HID_W-1:0]  last_grant_q, lock_hart_q;
  logic              lock_q;
  logic [HID_W-1:0]  rr_hart, rr_idx;
  logic              rr_found, handshake;
  logic [PC_W-1:0]   next_pc;

  // Round-robin search starting just after the last granted hart
  always_comb begin
    rr_found = 1'b0;
    rr_hart  = last_grant_q;
    rr_idx   = last_grant_q;
    for (int i = 1; i <= NUM_HARTS; i++) begin
      rr_idx = last_grant_q + HID_W'(i);
      if (!rr_found && state_q[rr_idx] == ST_RDY) begin
        rr_found = 1'b1;
        rr_hart  = rr_idx;
      end
    end
  end

  // A stalled offer stays pinned so a newly ready hart cannot steal the slot
  assign fetch_hart  = (lock_q && state_q[lock_hart_q] == ST_RDY) ? lock_hart_q : rr_hart;
  assign fetch_valid = rst_n && rr_found;
  assign fetch_pc    = pc_q[fetch_hart];
  assign handshake   = fetch_valid && fetch_ready;

  always_comb begin
    next_pc = wb_pc + PC_W'(4);
    case (wb_opcode)
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
        if (wb_alu_res == 32'd1) next_pc = wb_pc + (PC_W'(wb_imm) << 1);
      OP_JAL:  next_pc = wb_pc + (PC_W'(wb_imm) << 1);
      OP_JALR: next_pc = PC_W'(wb_rs1 + wb_imm) & ~PC_W'(1);
      OP_MRET: next_pc = mret_target;
      default: next_pc = wb_pc + PC_W'(4);
    endcase
  end

  always_comb begin
    wb_save_pc  = 1'b0;
    wb_link_val = 32'd0;
    if (wb_valid) begin
      case (wb_opcode)
        OP_JAL, OP_JALR: begin
          wb_save_pc  = 1'b1;
          wb_link_val = 32'(wb_pc) + 32'd4;
        end
        OP_AUIPC: begin
          wb_save_pc  = 1'b1;
          wb_link_val = 32'(wb_pc) + wb_imm;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pend_v_d = pend_v_q;
    for (int h = 0; h < NUM_HARTS; h++) begin
      logic wb_hit, irq_hit;
      state_d[h] = state_q[h];
      pc_d[h]    = pc_q[h];
      pend_d[h]  = pend_q[h];
      wb_hit  = wb_valid && wb_hart == HID_W'(h) && state_q[h] == ST_WAIT;
      irq_hit = irq_valid && irq_hart == HID_W'(h);
      case (state_q[h])
        ST_DIS:  if (hart_en[h]) state_d[h] = ST_RDY;
        ST_RDY: begin
          if (handshake && fetch_hart == HID_W'(h)) state_d[h] = ST_WAIT;
          else if (!hart_en[h])                     state_d[h] = ST_DIS;
        end
        ST_WAIT: if (wb_hit) state_d[h] = hart_en[h] ? ST_RDY : ST_DIS;
        default: state_d[h] = ST_DIS;
      endcase
      if (wb_hit) begin
        pc_d[h]     = pend_v_q[h] ? pend_q[h] : next_pc;
        pend_v_d[h] = 1'b0;
      end
      // An IRQ on an in-flight hart is deferred unless its wb lands the same cycle
      if (irq_hit) begin
        if (state_q[h] == ST_WAIT && !wb_hit) begin
          pend_d[h]   = irq_data;
          pend_v_d[h] = 1'b1;
        end else begin
          pc_d[h] = irq_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        state_q[h] <= ST_RDY;
        pc_q[h]    <= RESET_PC + PC_W'(h) * RESET_STRIDE;
        pend_q[h]  <= '0;
      end
      pend_v_q     <= '0;
      last_grant_q <= HID_W'(NUM_HARTS - 1);
      lock_q       <= 1'b0;
      lock_hart_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      if (handshake) begin
        last_grant_q <= fetch_hart;
        lock_q       <= 1'b0;
      end else if (fetch_valid) begin
        lock_q      <= 1'b1;
        lock_hart_q <= fetch_hart;
      end
    end
  end

  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) hart_busy[h] = (state_q[h] == ST_WAIT);
  end

endmodule
